serial_word_tx: RTL and testbench

Host-side bit-serial transmitter that feeds the bit-serial CPU core's serial input pin. It accepts parallel words over a valid/ready handshake and shifts each word out LSB-first on a single data line. A frame strobe and a first-bit marker travel with the data, so the core's serial receive path can align to word boundaries. The block sits in the top-level wrapper between the host-facing ui_in/uio_in registers and the core's serial input.

---
 rtl/serial_word_tx.sv | 154 +++++++++++++++
 tb/tb_serial_word_tx.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel word in over valid/ready, LSB-first bit-serial out
// with a frame strobe and a first-bit marker for word alignment downstream.
module serial_word_tx #(
    parameter int WIDTH = 16,
    parameter int DIV   = 1,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_frame,
    output logic             ser_first,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam bit            EARLY_OK = (GAP == 0);
    localparam bit            HAS_GAP  = (GAP > 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [DW-1:0]    div_cnt, div_cnt_n;
    logic [GW-1:0]    gap_cnt, gap_cnt_n;
    logic             ser_bit_n, ser_frame_n, ser_first_n, busy_n;
    logic             last_div, last_bit, xfer;

    // Handshake: ready in IDLE, or on the final bit cycle when no gap is configured.
    always_comb begin
        last_div = (div_cnt == DIV_LAST);
        last_bit = (bit_cnt == BIT_LAST);
        in_ready = !rst && en &&
                   ((state == ST_IDLE) ||
                    (EARLY_OK && (state == ST_SHIFT) && last_div && last_bit));
        xfer     = in_valid && in_ready;
    end

    // Next-state and next-output logic; all outputs below are registered.
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        div_cnt_n   = div_cnt;
        gap_cnt_n   = gap_cnt;
        ser_bit_n   = ser_bit;
        ser_frame_n = ser_frame;
        ser_first_n = ser_first;
        busy_n      = busy;

        unique case (state)
            ST_IDLE: begin
                if (xfer) begin
                    state_n     = ST_SHIFT;
                    shreg_n     = in_data;
                    bit_cnt_n   = '0;
                    div_cnt_n   = '0;
                    ser_bit_n   = in_data[0];
                    ser_frame_n = 1'b1;
                    ser_first_n = 1'b1;
                    busy_n      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!last_div) begin
                    div_cnt_n = div_cnt + 1'b1;
                end else begin
                    div_cnt_n = '0;
                    if (!last_bit) begin
                        shreg_n     = {1'b0, shreg[WIDTH-1:1]};
                        ser_bit_n   = shreg[1];
                        bit_cnt_n   = bit_cnt + 1'b1;
                        ser_first_n = 1'b0;
                    end else if (xfer) begin
                        // Gapless reload: next word's bit 0 follows the MSB directly.
                        shreg_n     = in_data;
                        bit_cnt_n   = '0;
                        ser_bit_n   = in_data[0];
                        ser_frame_n = 1'b1;
                        ser_first_n = 1'b1;
                        busy_n      = 1'b1;
                    end else if (HAS_GAP) begin
                        state_n     = ST_GAP;
                        gap_cnt_n   = '0;
                        bit_cnt_n   = '0;
                        ser_bit_n   = 1'b0;
                        ser_frame_n = 1'b0;
                        ser_first_n = 1'b0;
                    end else begin
                        state_n     = ST_IDLE;
                        bit_cnt_n   = '0;
                        ser_bit_n   = 1'b0;
                        ser_frame_n = 1'b0;
                        ser_first_n = 1'b0;
                        busy_n      = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n   = ST_IDLE;
                    gap_cnt_n = '0;
                    busy_n    = 1'b0;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            gap_cnt   <= '0;
            ser_bit   <= 1'b0;
            ser_frame <= 1'b0;
            ser_first <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            div_cnt   <= div_cnt_n;
            gap_cnt   <= gap_cnt_n;
            ser_bit   <= ser_bit_n;
            ser_frame <= ser_frame_n;
            ser_first <= ser_first_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: three instances cover GAP=1/DIV=1,
// GAP=1/DIV=3 and GAP=0/DIV=1. Observed outputs are packed as
// {ser_bit, ser_frame, ser_first, busy}.
module tb_serial_word_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        en_a = 1'b0, valid_a = 1'b0, ready_a, bit_a, frame_a, first_a, busy_a;
    logic [15:0] data_a = '0;
    logic        en_b = 1'b0, valid_b = 1'b0, ready_b, bit_b, frame_b, first_b, busy_b;
    logic [15:0] data_b = '0;
    logic        en_c = 1'b0, valid_c = 1'b0, ready_c, bit_c, frame_c, first_c, busy_c;
    logic [15:0] data_c = '0;

    int n_cmp = 0;
    int n_bad = 0;

    serial_word_tx #(.WIDTH(16), .DIV(1), .GAP(1)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .in_data(data_a), .in_valid(valid_a),
        .in_ready(ready_a), .ser_bit(bit_a), .ser_frame(frame_a),
        .ser_first(first_a), .busy(busy_a)
    );

    serial_word_tx #(.WIDTH(16), .DIV(3), .GAP(1)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .in_data(data_b), .in_valid(valid_b),
        .in_ready(ready_b), .ser_bit(bit_b), .ser_frame(frame_b),
        .ser_first(first_b), .busy(busy_b)
    );

    serial_word_tx #(.WIDTH(16), .DIV(1), .GAP(0)) u_c (
        .clk(clk), .rst(rst), .en(en_c), .in_data(data_c), .in_valid(valid_c),
        .in_ready(ready_c), .ser_bit(bit_c), .ser_frame(frame_c),
        .ser_first(first_c), .busy(busy_c)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        tick();
        n_cmp++;
        if ({bit_a, frame_a, first_a, busy_a, ready_a} !== 5'b0) begin
            $display("FAIL reset_a got=%b exp=00000", {bit_a, frame_a, first_a, busy_a, ready_a});
            n_bad++;
        end
        n_cmp++;
        if ({bit_b, frame_b, first_b, busy_b, ready_b} !== 5'b0) begin
            $display("FAIL reset_b got=%b exp=00000", {bit_b, frame_b, first_b, busy_b, ready_b});
            n_bad++;
        end
        n_cmp++;
        if ({bit_c, frame_c, first_c, busy_c, ready_c} !== 5'b0) begin
            $display("FAIL reset_c got=%b exp=00000", {bit_c, frame_c, first_c, busy_c, ready_c});
            n_bad++;
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ready_a !== 1'b1) begin
            $display("FAIL ready_after_reset got=%b exp=1", ready_a);
            n_bad++;
        end
    endtask

    task automatic test_single_word();
        logic [15:0] w;
        logic [3:0]  e;
        w = 16'hA5C3;
        data_a = w; valid_a = 1'b1;
        #1;
        n_cmp++;
        if (ready_a !== 1'b1) begin
            $display("FAIL single_ready got=%b exp=1", ready_a);
            n_bad++;
        end
        tick();
        valid_a = 1'b0; data_a = '0;
        for (int i = 0; i < 16; i++) begin
            e = {w[i], 1'b1, (i == 0), 1'b1};
            n_cmp++;
            if ({bit_a, frame_a, first_a, busy_a} !== e) begin
                $display("FAIL single_bit%0d got=%b exp=%b", i, {bit_a, frame_a, first_a, busy_a}, e);
                n_bad++;
            end
            tick();
        end
        n_cmp++;
        if ({bit_a, frame_a, first_a, busy_a, ready_a} !== 5'b00010) begin
            $display("FAIL single_gap got=%b exp=00010", {bit_a, frame_a, first_a, busy_a, ready_a});
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({bit_a, frame_a, first_a, busy_a, ready_a} !== 5'b00001) begin
            $display("FAIL single_idle got=%b exp=00001", {bit_a, frame_a, first_a, busy_a, ready_a});
            n_bad++;
        end
    endtask

    task automatic test_divider();
        logic [3:0] e;
        data_b = 16'h0001; valid_b = 1'b1;
        #1;
        n_cmp++;
        if (ready_b !== 1'b1) begin
            $display("FAIL div_ready got=%b exp=1", ready_b);
            n_bad++;
        end
        tick();
        valid_b = 1'b0;
        for (int i = 0; i < 48; i++) begin
            e = {(i < 3), 1'b1, (i < 3), 1'b1};
            n_cmp++;
            if ({bit_b, frame_b, first_b, busy_b} !== e) begin
                $display("FAIL div_cycle%0d got=%b exp=%b", i, {bit_b, frame_b, first_b, busy_b}, e);
                n_bad++;
            end
            tick();
        end
        n_cmp++;
        if ({bit_b, frame_b, first_b, busy_b} !== 4'b0001) begin
            $display("FAIL div_gap got=%b exp=0001", {bit_b, frame_b, first_b, busy_b});
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({bit_b, frame_b, first_b, busy_b} !== 4'b0000) begin
            $display("FAIL div_idle got=%b exp=0000", {bit_b, frame_b, first_b, busy_b});
            n_bad++;
        end
    endtask

    task automatic test_gapless();
        logic [3:0] e;
        data_c = 16'hFFFF; valid_c = 1'b1;
        #1;
        n_cmp++;
        if (ready_c !== 1'b1) begin
            $display("FAIL gapless_ready0 got=%b exp=1", ready_c);
            n_bad++;
        end
        tick();
        data_c = 16'h0000;
        for (int i = 0; i < 32; i++) begin
            e = {(i < 16), 1'b1, (i == 0 || i == 16), 1'b1};
            n_cmp++;
            if ({bit_c, frame_c, first_c, busy_c} !== e) begin
                $display("FAIL gapless_cycle%0d got=%b exp=%b", i + 1, {bit_c, frame_c, first_c, busy_c}, e);
                n_bad++;
            end
            n_cmp++;
            if (ready_c !== ((i == 15) || (i == 31))) begin
                $display("FAIL gapless_ready%0d got=%b exp=%b", i + 1, ready_c, ((i == 15) || (i == 31)));
                n_bad++;
            end
            if (i == 16) valid_c = 1'b0;
            tick();
        end
        n_cmp++;
        if ({bit_c, frame_c, first_c, busy_c, ready_c} !== 5'b00001) begin
            $display("FAIL gapless_idle got=%b exp=00001", {bit_c, frame_c, first_c, busy_c, ready_c});
            n_bad++;
        end
    endtask

    task automatic test_enable();
        logic [15:0] w;
        logic [3:0]  e;
        w = 16'h1234;
        data_a = w; valid_a = 1'b1; en_a = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                en_a = 1'b0;
                #1;
            end
            e = {w[i], 1'b1, (i == 0), 1'b1};
            n_cmp++;
            if ({bit_a, frame_a, first_a, busy_a} !== e) begin
                $display("FAIL en_bit%0d got=%b exp=%b", i, {bit_a, frame_a, first_a, busy_a}, e);
                n_bad++;
            end
            tick();
        end
        n_cmp++;
        if ({bit_a, frame_a, first_a, busy_a} !== 4'b0001) begin
            $display("FAIL en_gap got=%b exp=0001", {bit_a, frame_a, first_a, busy_a});
            n_bad++;
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({bit_a, frame_a, first_a, busy_a, ready_a} !== 5'b00000) begin
                $display("FAIL en_hold%0d got=%b exp=00000", i, {bit_a, frame_a, first_a, busy_a, ready_a});
                n_bad++;
            end
            tick();
        end
        en_a = 1'b1;
        #1;
        n_cmp++;
        if (ready_a !== 1'b1) begin
            $display("FAIL en_resume_ready got=%b exp=1", ready_a);
            n_bad++;
        end
        tick();
        valid_a = 1'b0;
        n_cmp++;
        if ({bit_a, frame_a, first_a, busy_a} !== 4'b0111) begin
            $display("FAIL en_resume_bit0 got=%b exp=0111", {bit_a, frame_a, first_a, busy_a});
            n_bad++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] e;
        data_a = 16'hFFFF; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e = {1'b1, 1'b1, (i == 0), 1'b1};
            n_cmp++;
            if ({bit_a, frame_a, first_a, busy_a} !== e) begin
                $display("FAIL rstmid_bit%0d got=%b exp=%b", i, {bit_a, frame_a, first_a, busy_a}, e);
                n_bad++;
            end
            if (i < 7) tick();
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({bit_a, frame_a, first_a, busy_a, ready_a} !== 5'b00000) begin
            $display("FAIL rstmid_edge got=%b exp=00000", {bit_a, frame_a, first_a, busy_a, ready_a});
            n_bad++;
        end
        rst = 1'b0;
        data_a = 16'h0003; valid_a = 1'b1;
        #1;
        n_cmp++;
        if (ready_a !== 1'b1) begin
            $display("FAIL rstmid_ready got=%b exp=1", ready_a);
            n_bad++;
        end
        tick();
        valid_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e = {(i < 2), 1'b1, (i == 0), 1'b1};
            n_cmp++;
            if ({bit_a, frame_a, first_a, busy_a} !== e) begin
                $display("FAIL rstmid_new%0d got=%b exp=%b", i, {bit_a, frame_a, first_a, busy_a}, e);
                n_bad++;
            end
            tick();
        end
        for (int i = 0; i < 14; i++) tick();
        n_cmp++;
        if ({bit_a, frame_a, first_a, busy_a} !== 4'b0000) begin
            $display("FAIL rstmid_idle got=%b exp=0000", {bit_a, frame_a, first_a, busy_a});
            n_bad++;
        end
    endtask

    task automatic test_input_stability();
        logic [15:0] w;
        logic [3:0]  e;
        w = 16'hBEEF;
        data_a = w; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        data_a = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            e = {w[i], 1'b1, (i == 0), 1'b1};
            n_cmp++;
            if ({bit_a, frame_a, first_a, busy_a} !== e) begin
                $display("FAIL stable_bit%0d got=%b exp=%b", i, {bit_a, frame_a, first_a, busy_a}, e);
                n_bad++;
            end
            tick();
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_divider();
        test_gapless();
        test_enable();
        test_reset_mid();
        test_input_stability();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
